// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the pipelined adder/subtractor.
//   - OP_ADD / OP_SUB : encodings of the 'sub' mode input.
//   - slice_w()       : per-stage slice width (WIDTH / STAGES).
//   - sat_max/sat_min : signed max/min bit patterns for a given width, returned
//                       in a 64-bit container (callers take the low bits).
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // WIDTH must be a multiple of STAGES; no remainder slice is handled.
   function automatic int slice_w(input int width, input int stages);
      return width / stages;
   endfunction

   // 0 followed by (width-1) ones.
   function automatic logic [63:0] sat_max(input int width);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < width - 1; i++) r[i] = 1'b1;
      return r;
   endfunction

   // 1 followed by (width-1) zeros.
   function automatic logic [63:0] sat_min(input int width);
      logic [63:0] r;
      r = '0;
      r[width-1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/adder_fa.sv
// -----------------------------------------------------------------------------
// adder_fa
//   One-bit full-adder cell.
//   Ports: a_i, b_i, c_i (inputs) -> s_o (sum), c_o (carry out).
// -----------------------------------------------------------------------------
module adder_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
//   Combinational SW-bit ripple-carry chain built from adder_fa cells.
//   Ports:
//     a_i, b_i [SW-1:0] : slice operands (b already inverted for subtract)
//     c_i               : carry into bit 0
//     s_o      [SW-1:0] : slice sum
//     c_o               : carry out of the slice MSB
//     c_msb_o           : carry into the slice MSB (for overflow detection)
// -----------------------------------------------------------------------------
module adder_slice #(
   parameter int SW = 4
) (
   input  logic [SW-1:0] a_i,
   input  logic [SW-1:0] b_i,
   input  logic          c_i,
   output logic [SW-1:0] s_o,
   output logic          c_o,
   output logic          c_msb_o
);

   // Carry kept per bit block rather than in one vector so the chain is not
   // seen as a self-referencing signal.
   for (genvar i = 0; i < SW; i++) begin : g_bit
      logic ci, co;
      if (i == 0) begin : g_c
         assign ci = c_i;
      end else begin : g_c
         assign ci = g_bit[i-1].co;
      end
      adder_fa u_fa (
         .a_i (a_i[i]),
         .b_i (b_i[i]),
         .c_i (ci),
         .s_o (s_o[i]),
         .c_o (co)
      );
   end

   assign c_o     = g_bit[SW-1].co;
   assign c_msb_o = g_bit[SW-1].ci;

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   Pipelined ripple-carry adder/subtractor. WIDTH is split into STAGES slices
//   of SW = WIDTH/STAGES bits; stage k adds slice k and registers the partial
//   sum, the carry and the not-yet-consumed upper operand bits. One beat per
//   cycle, valid/ready handshake, whole pipe stalls together on back-pressure.
//   Latency: a beat presented (and accepted) in cycle N is on the outputs in
//   cycle N+STAGES.
//
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     in_valid/in_ready  : operand handshake (in_ready = !out_valid || out_ready)
//     a, b [WIDTH-1:0]   : operands
//     cin                : carry-in (add mode only)
//     sub                : OP_ADD: a+b+cin, OP_SUB: a + ~b + 1
//     out_valid/out_ready: result handshake
//     sum [WIDTH-1:0]    : result modulo 2^WIDTH
//     cout               : carry out of MSB (subtract: 1 = no borrow)
//     overflow           : signed overflow (carry into MSB ^ carry out)
//
//   Build option: define PIPELINED_ADDER_SAT_EN to saturate 'sum' to the
//   signed max/min on overflow (cout/overflow keep their unsaturated values).
// -----------------------------------------------------------------------------
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int SW = slice_w(WIDTH, STAGES);

   logic              en;
   logic [STAGES-1:0] vld_q;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;

   // Single enable for every stage: bubbles advance too, nothing is compressed.
   assign en        = !vld_q[STAGES-1] || out_ready;
   assign in_ready  = en;
   assign out_valid = vld_q[STAGES-1];
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int LO = k * SW;
      localparam int HI = LO + SW - 1;

      logic [WIDTH-1:LO] a_up, b_up;   // operand bits not yet consumed
      logic [HI:0]       s_all;        // result bits resolved so far
      logic [SW-1:0]     s_sl;
      logic              c_in, c_out, c_msb;

      if (k == 0) begin : g_in
         assign a_up = a;
         assign b_up = (sub == OP_SUB) ? ~b : b;
         assign c_in = (sub == OP_SUB) ? 1'b1 : cin;
         assign s_all = s_sl;
      end else begin : g_in
         assign a_up  = g_st[k-1].g_reg.a_q;
         assign b_up  = g_st[k-1].g_reg.b_q;
         assign c_in  = g_st[k-1].g_reg.c_q;
         assign s_all = {s_sl, g_st[k-1].g_reg.s_q};
      end

      adder_slice #(.SW(SW)) u_slice (
         .a_i     (a_up[HI:LO]),
         .b_i     (b_up[HI:LO]),
         .c_i     (c_in),
         .s_o     (s_sl),
         .c_o     (c_out),
         .c_msb_o (c_msb)
      );

      if (k < STAGES - 1) begin : g_reg
         logic [WIDTH-1:HI+1] a_q, b_q;
         logic [HI:0]         s_q;
         logic                c_q;
         logic                unused_c_msb;

         // Carry into an inner slice MSB has no meaning for the result.
         assign unused_c_msb = c_msb;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
               s_q <= '0;
               c_q <= 1'b0;
            end else if (en) begin
               a_q <= a_up[WIDTH-1:HI+1];
               b_q <= b_up[WIDTH-1:HI+1];
               s_q <= s_all;
               c_q <= c_out;
            end
         end
      end else begin : g_out
         assign cout_d = c_out;
         assign ovf_d  = c_out ^ c_msb;
`ifdef PIPELINED_ADDER_SAT_EN
         localparam logic [63:0] SMAX = sat_max(WIDTH);
         localparam logic [63:0] SMIN = sat_min(WIDTH);
         // On overflow both effective operands share a sign, which is the
         // sign of the true result.
         assign sum_d = !ovf_d          ? s_all :
                        a_up[WIDTH-1]   ? SMIN[WIDTH-1:0] : SMAX[WIDTH-1:0];
`else
         assign sum_d = s_all;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (en) begin
         vld_q[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) vld_q[k] <= vld_q[k-1];
         sum_q  <= sum_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
      end
   end

endmodule
